// File: rtl/ram_dist_pkg.sv
// Shared constants for the distributed measurement buffer: default geometry,
// write-mode encodings and the value reported when no entry is valid.
package ram_dist_pkg;

   localparam int DEF_WIDTH = 13;
   localparam int DEF_DEPTH = 6;

   localparam logic MODE_ADDR = 1'b0;
   localparam logic MODE_AUTO = 1'b1;

   // Sliced down to the entry width by users; supports entries up to 64 bits.
   localparam logic [63:0] MIN_EMPTY_VAL = {64{1'b1}};

endpackage

// File: rtl/ram_dist_buffer_if.sv
// Write/readback bundle between the capture logic (master) and the buffer (slave).
interface ram_dist_buffer_if
   import ram_dist_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH
);
   localparam int AW = $clog2(DEPTH);

   logic                   mode;
   logic                   we;
   logic [AW-1:0]          addr;
   logic [WIDTH-1:0]       data;
   logic [WIDTH*DEPTH-1:0] q_all;
   logic [DEPTH-1:0]       valid_mask;
   logic [AW-1:0]          wr_ptr;
   logic                   full;
   logic                   wr_ack;
   logic                   wr_err;
   logic [WIDTH-1:0]       min_val;
   logic [AW-1:0]          min_idx;

   modport master (
      output mode, we, addr, data,
      input  q_all, valid_mask, wr_ptr, full, wr_ack, wr_err, min_val, min_idx
   );

   modport slave (
      input  mode, we, addr, data,
      output q_all, valid_mask, wr_ptr, full, wr_ack, wr_err, min_val, min_idx
   );

endinterface

// File: rtl/ram_dist_min.sv
// Combinational min/argmin over the valid entries of a flattened bus; used only
// when RAM_DIST_MIN_TRACK_EN is defined. Ties go to the lowest index.
module ram_dist_min
   import ram_dist_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic [WIDTH*DEPTH-1:0] q_all,
   input  logic [DEPTH-1:0]       mask,
   output logic [WIDTH-1:0]       min_val,
   output logic [AW-1:0]          min_idx
);

   localparam logic [WIDTH-1:0] EMPTY_VAL = MIN_EMPTY_VAL[WIDTH-1:0];

   logic found_s;

   // Linear scan; strict less-than keeps the earliest index on equal values.
   always_comb begin
      min_val = EMPTY_VAL;
      min_idx = {AW{1'b0}};
      found_s = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (mask[i] && (!found_s || (q_all[i*WIDTH +: WIDTH] < min_val))) begin
            min_val = q_all[i*WIDTH +: WIDTH];
            min_idx = AW'(i);
            found_s = 1'b1;
         end else begin
            found_s = found_s;
         end
      end
   end

endmodule

// File: rtl/ram_dist_buffer.sv
// Parametrised distributed buffer with staged addressed/auto-increment writes
// and parallel readback. Optional minimum tracking under RAM_DIST_MIN_TRACK_EN.
module ram_dist_buffer
   import ram_dist_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter int DEPTH     = DEF_DEPTH,
   parameter int OVERWRITE = 0
) (
   input logic              clk,
   input logic              clear_n,
   input logic              sclr,
   ram_dist_buffer_if.slave bus
);

   localparam int            AW       = $clog2(DEPTH);
   localparam logic [AW:0]   DEPTH_X  = (AW+1)'(DEPTH);
   localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);

   logic [WIDTH-1:0]       mem_r [DEPTH];
   logic [DEPTH-1:0]       valid_r;
   logic [AW-1:0]          ptr_r;
   logic                   stg_v_r;
   logic                   stg_mode_r;
   logic [AW-1:0]          stg_addr_r;
   logic [WIDTH-1:0]       stg_data_r;
   logic                   ack_r;
   logic                   err_r;

   logic                   full_s;
   logic                   commit_s;
   logic                   drop_s;
   logic [AW-1:0]          tgt_s;
   logic [WIDTH*DEPTH-1:0] q_all_s;

   assign full_s = &valid_r;

   // Resolve the staged write into a target entry, or drop it.
   always_comb begin
      commit_s = 1'b0;
      drop_s   = 1'b0;
      tgt_s    = {AW{1'b0}};
      if (stg_v_r) begin
         if (stg_mode_r == MODE_ADDR) begin
            if ({1'b0, stg_addr_r} < DEPTH_X) begin
               commit_s = 1'b1;
               tgt_s    = stg_addr_r;
            end else begin
               drop_s = 1'b1;
            end
         end else begin
            if (full_s && (OVERWRITE == 0)) begin
               drop_s = 1'b1;
            end else begin
               commit_s = 1'b1;
               tgt_s    = ptr_r;
            end
         end
      end else begin
         commit_s = 1'b0;
      end
   end

   // Entry storage and per-entry valid flags.
   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         valid_r <= {DEPTH{1'b0}};
         for (int i = 0; i < DEPTH; i++) mem_r[i] <= {WIDTH{1'b0}};
      end else if (sclr) begin
         valid_r <= {DEPTH{1'b0}};
         for (int i = 0; i < DEPTH; i++) mem_r[i] <= {WIDTH{1'b0}};
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (commit_s && (int'(tgt_s) == i)) begin
               mem_r[i]   <= stg_data_r;
               valid_r[i] <= 1'b1;
            end else begin
               mem_r[i]   <= mem_r[i];
               valid_r[i] <= valid_r[i];
            end
         end
      end
   end

   // Write stage, auto pointer and the one-cycle ack/err pulses.
   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         ptr_r      <= {AW{1'b0}};
         stg_v_r    <= 1'b0;
         stg_mode_r <= 1'b0;
         stg_addr_r <= {AW{1'b0}};
         stg_data_r <= {WIDTH{1'b0}};
         ack_r      <= 1'b0;
         err_r      <= 1'b0;
      end else if (sclr) begin
         ptr_r      <= {AW{1'b0}};
         stg_v_r    <= 1'b0;
         stg_mode_r <= 1'b0;
         stg_addr_r <= {AW{1'b0}};
         stg_data_r <= {WIDTH{1'b0}};
         ack_r      <= 1'b0;
         err_r      <= 1'b0;
      end else begin
         stg_v_r <= bus.we;
         if (bus.we) begin
            stg_mode_r <= bus.mode;
            stg_addr_r <= bus.addr;
            stg_data_r <= bus.data;
         end else begin
            stg_mode_r <= stg_mode_r;
            stg_addr_r <= stg_addr_r;
            stg_data_r <= stg_data_r;
         end
         ack_r <= commit_s;
         err_r <= drop_s;
         if (commit_s && (stg_mode_r == MODE_AUTO)) begin
            ptr_r <= (ptr_r == PTR_LAST) ? {AW{1'b0}} : (ptr_r + PTR_ONE);
         end else begin
            ptr_r <= ptr_r;
         end
      end
   end

   // Flatten storage onto the parallel readback bus.
   always_comb begin
      q_all_s = {(WIDTH*DEPTH){1'b0}};
      for (int i = 0; i < DEPTH; i++) q_all_s[i*WIDTH +: WIDTH] = mem_r[i];
   end

   assign bus.q_all      = q_all_s;
   assign bus.valid_mask = valid_r;
   assign bus.wr_ptr     = ptr_r;
   assign bus.full       = full_s;
   assign bus.wr_ack     = ack_r;
   assign bus.wr_err     = err_r;

`ifdef RAM_DIST_MIN_TRACK_EN
   logic [WIDTH-1:0] min_s;
   logic [AW-1:0]    min_idx_s;
   logic [WIDTH-1:0] min_val_r;
   logic [AW-1:0]    min_idx_r;

   ram_dist_min #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_min (
      .q_all   (q_all_s),
      .mask    (valid_r),
      .min_val (min_s),
      .min_idx (min_idx_s)
   );

   // Registered copy lags the storage by one cycle, including across sclr.
   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         min_val_r <= {WIDTH{1'b0}};
         min_idx_r <= {AW{1'b0}};
      end else begin
         min_val_r <= min_s;
         min_idx_r <= min_idx_s;
      end
   end

   assign bus.min_val = min_val_r;
   assign bus.min_idx = min_idx_r;
`else
   assign bus.min_val = {WIDTH{1'b0}};
   assign bus.min_idx = {AW{1'b0}};
`endif

endmodule

// File: tb/tb_ram_dist_buffer.sv
// Bench for ram_dist_buffer: two instances (drop / overwrite when full) driven
// identically, checked by a directed vector table and a random phase against a model.
module tb_ram_dist_buffer;
   import ram_dist_pkg::*;

   localparam int W  = 13;
   localparam int D  = 6;
   localparam int AW = 3;

   logic clk = 1'b0;
   logic clear_n;
   logic sclr;

   always #5 clk = ~clk;

   ram_dist_buffer_if #(.WIDTH(W), .DEPTH(D)) bus0 ();
   ram_dist_buffer_if #(.WIDTH(W), .DEPTH(D)) bus1 ();

   ram_dist_buffer #(.WIDTH(W), .DEPTH(D), .OVERWRITE(0)) dut0 (
      .clk(clk), .clear_n(clear_n), .sclr(sclr), .bus(bus0.slave));
   ram_dist_buffer #(.WIDTH(W), .DEPTH(D), .OVERWRITE(1)) dut1 (
      .clk(clk), .clear_n(clear_n), .sclr(sclr), .bus(bus1.slave));

   int checks = 0;
   int errors = 0;

   // Reference model: one storage image per instance, shared pending write.
   logic [W-1:0] m_mem [2][D];
   bit           m_vld [2][D];
   int           m_ptr [2];
   bit           m_ack [2];
   bit           m_err [2];
   logic [W-1:0] m_min [2];
   int           m_midx[2];
   bit           p_v;
   bit           p_mode;
   int           p_addr;
   logic [W-1:0] p_data;

   typedef struct {
      bit s, w, m; int a, d;
      bit e_ack, e_err; int e_mask, e_ptr; bit e_full; int e_idx, e_val;
      bit chk_min; int e_min, e_midx;
   } vec_t;
   vec_t tv[27];

   function automatic vec_t mk(bit s, w, m, int a, d, bit ea, ee, int emask, eptr,
                               bit ef, int eidx, eval, bit cm, int emin, emidx);
      vec_t v;
      v = '{s, w, m, a, d, ea, ee, emask, eptr, ef, eidx, eval, cm, emin, emidx};
      return v;
   endfunction

   task automatic cmp(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < D; i++) begin m_mem[k][i] = '0; m_vld[k][i] = 1'b0; end
         m_ptr[k] = 0; m_ack[k] = 1'b0; m_err[k] = 1'b0; m_min[k] = '0; m_midx[k] = 0;
      end
      p_v = 1'b0;
   endtask

   function automatic bit model_full(int k);
      for (int i = 0; i < D; i++) if (!m_vld[k][i]) return 1'b0;
      return 1'b1;
   endfunction

   task automatic model_edge(input bit s, w, m, input int a, input int d);
      for (int k = 0; k < 2; k++) begin
         // minimum value first, then the first index holding it
         int mv; int mi;
         mv = 32'h1FFF; mi = 0;
         for (int i = 0; i < D; i++) if (m_vld[k][i] && int'(m_mem[k][i]) < mv) mv = int'(m_mem[k][i]);
         for (int i = D - 1; i >= 0; i--) if (m_vld[k][i] && int'(m_mem[k][i]) == mv) mi = i;
         m_min[k] = mv[W-1:0]; m_midx[k] = mi;
         m_ack[k] = 1'b0; m_err[k] = 1'b0;
         if (s) begin
            for (int i = 0; i < D; i++) begin m_mem[k][i] = '0; m_vld[k][i] = 1'b0; end
            m_ptr[k] = 0;
         end else if (p_v) begin
            if (p_mode == 1'b0) begin
               if (p_addr < D) begin
                  m_mem[k][p_addr] = p_data; m_vld[k][p_addr] = 1'b1; m_ack[k] = 1'b1;
               end else m_err[k] = 1'b1;
            end else if (model_full(k) && k == 0) begin
               m_err[k] = 1'b1;
            end else begin
               m_mem[k][m_ptr[k]] = p_data; m_vld[k][m_ptr[k]] = 1'b1;
               m_ptr[k] = (m_ptr[k] + 1) % D; m_ack[k] = 1'b1;
            end
         end
      end
      p_v = w && !s; p_mode = m; p_addr = a; p_data = d[W-1:0];
   endtask

   task automatic check_all();
      for (int k = 0; k < 2; k++) begin
         logic [W*D-1:0] q, eq; logic [D-1:0] vm, evm; logic [AW-1:0] wp, midx;
         logic fl, ak, er; logic [W-1:0] mv; logic [W-1:0] emv; int emi;
         if (k == 0) begin
            q = bus0.q_all; vm = bus0.valid_mask; wp = bus0.wr_ptr; fl = bus0.full;
            ak = bus0.wr_ack; er = bus0.wr_err; mv = bus0.min_val; midx = bus0.min_idx;
         end else begin
            q = bus1.q_all; vm = bus1.valid_mask; wp = bus1.wr_ptr; fl = bus1.full;
            ak = bus1.wr_ack; er = bus1.wr_err; mv = bus1.min_val; midx = bus1.min_idx;
         end
         for (int i = 0; i < D; i++) begin eq[i*W +: W] = m_mem[k][i]; evm[i] = m_vld[k][i]; end
`ifdef RAM_DIST_MIN_TRACK_EN
         emv = m_min[k]; emi = m_midx[k];
`else
         emv = '0; emi = 0;
`endif
         cmp($sformatf("u%0d.q_all", k), q, eq);
         cmp($sformatf("u%0d.valid_mask", k), vm, evm);
         cmp($sformatf("u%0d.wr_ptr", k), wp, m_ptr[k]);
         cmp($sformatf("u%0d.full", k), fl, model_full(k));
         cmp($sformatf("u%0d.wr_ack", k), ak, m_ack[k]);
         cmp($sformatf("u%0d.wr_err", k), er, m_err[k]);
         cmp($sformatf("u%0d.min_val", k), mv, emv);
         cmp($sformatf("u%0d.min_idx", k), midx, emi);
      end
   endtask

   task automatic drive(input bit s, w, m, input int a, input int d);
      sclr = s;
      bus0.we = w; bus0.mode = m; bus0.addr = a[AW-1:0]; bus0.data = d[W-1:0];
      bus1.we = w; bus1.mode = m; bus1.addr = a[AW-1:0]; bus1.data = d[W-1:0];
   endtask

   task automatic step(input bit s, w, m, input int a, input int d);
      drive(s, w, m, a, d);
      @(posedge clk);
      if (!clear_n) model_reset();
      else model_edge(s, w, m, a, d);
      #1;
      check_all();
   endtask

   initial begin
      //         s  w  m  a  d        ack err mask        ptr full idx val     min
      tv[0]  = mk(0, 1, 0, 5, 'h1ABC,  0, 0, 'b000000, 0, 0, 5, 0,        0, 0, 0);
      tv[1]  = mk(0, 0, 0, 0, 0,       1, 0, 'b100000, 0, 0, 5, 'h1ABC,   0, 0, 0);
      tv[2]  = mk(0, 0, 0, 0, 0,       0, 0, 'b100000, 0, 0, 5, 'h1ABC,   0, 0, 0);
      tv[3]  = mk(0, 1, 0, 6, 77,      0, 0, 'b100000, 0, 0, 5, 'h1ABC,   0, 0, 0);
      tv[4]  = mk(0, 1, 0, 7, 55,      0, 1, 'b100000, 0, 0, 5, 'h1ABC,   0, 0, 0);
      tv[5]  = mk(0, 0, 0, 0, 0,       0, 1, 'b100000, 0, 0, 5, 'h1ABC,   0, 0, 0);
      tv[6]  = mk(0, 0, 0, 0, 0,       0, 0, 'b100000, 0, 0, 5, 'h1ABC,   0, 0, 0);
      tv[7]  = mk(1, 1, 0, 0, 3,       0, 0, 'b000000, 0, 0, 5, 0,        0, 0, 0);
      tv[8]  = mk(0, 0, 0, 0, 0,       0, 0, 'b000000, 0, 0, 0, 0,        0, 0, 0);
      tv[9]  = mk(0, 1, 1, 0, 10,      0, 0, 'b000000, 0, 0, 0, 0,        0, 0, 0);
      tv[10] = mk(0, 1, 1, 0, 11,      1, 0, 'b000001, 1, 0, 0, 10,       0, 0, 0);
      tv[11] = mk(0, 1, 1, 0, 12,      1, 0, 'b000011, 2, 0, 1, 11,       0, 0, 0);
      tv[12] = mk(0, 1, 1, 0, 13,      1, 0, 'b000111, 3, 0, 2, 12,       0, 0, 0);
      tv[13] = mk(0, 1, 1, 0, 14,      1, 0, 'b001111, 4, 0, 3, 13,       0, 0, 0);
      tv[14] = mk(0, 1, 1, 0, 15,      1, 0, 'b011111, 5, 0, 4, 14,       0, 0, 0);
      tv[15] = mk(0, 1, 1, 0, 99,      1, 0, 'b111111, 0, 1, 5, 15,       0, 0, 0);
      tv[16] = mk(0, 0, 0, 0, 0,       0, 1, 'b111111, 0, 1, 0, 10,       0, 0, 0);
      tv[17] = mk(0, 1, 1, 0, 5,       0, 0, 'b111111, 0, 1, 0, 10,       0, 0, 0);
      tv[18] = mk(1, 1, 1, 0, 6,       0, 0, 'b000000, 0, 0, 0, 0,        0, 0, 0);
      tv[19] = mk(0, 0, 0, 0, 0,       0, 0, 'b000000, 0, 0, 0, 0,        1, 'h1FFF, 0);
      tv[20] = mk(0, 1, 0, 1, 300,     0, 0, 'b000000, 0, 0, 1, 0,        0, 0, 0);
      tv[21] = mk(0, 1, 0, 3, 120,     1, 0, 'b000010, 0, 0, 1, 300,      0, 0, 0);
      tv[22] = mk(0, 1, 0, 4, 120,     1, 0, 'b001010, 0, 0, 3, 120,      0, 0, 0);
      tv[23] = mk(0, 0, 0, 0, 0,       1, 0, 'b011010, 0, 0, 4, 120,      1, 120, 3);
      tv[24] = mk(0, 0, 0, 0, 0,       0, 0, 'b011010, 0, 0, 3, 120,      1, 120, 3);
      tv[25] = mk(1, 0, 0, 0, 0,       0, 0, 'b000000, 0, 0, 3, 0,        1, 120, 3);
      tv[26] = mk(0, 0, 0, 0, 0,       0, 0, 'b000000, 0, 0, 4, 0,        1, 'h1FFF, 0);

      // Reset held with a write request present.
      clear_n = 1'b0;
      model_reset();
      for (int i = 0; i < 3; i++) step(0, 1, 0, 5, 'h1ABC);
      clear_n = 1'b1;

      for (int i = 0; i < 27; i++) begin
         step(tv[i].s, tv[i].w, tv[i].m, tv[i].a, tv[i].d);
         cmp($sformatf("v%0d.ack", i), bus0.wr_ack, tv[i].e_ack);
         cmp($sformatf("v%0d.err", i), bus0.wr_err, tv[i].e_err);
         cmp($sformatf("v%0d.mask", i), bus0.valid_mask, tv[i].e_mask);
         cmp($sformatf("v%0d.ptr", i), bus0.wr_ptr, tv[i].e_ptr);
         cmp($sformatf("v%0d.full", i), bus0.full, tv[i].e_full);
         cmp($sformatf("v%0d.entry", i), bus0.q_all[tv[i].e_idx*W +: W], tv[i].e_val);
`ifdef RAM_DIST_MIN_TRACK_EN
         if (tv[i].chk_min) begin
            cmp($sformatf("v%0d.min_val", i), bus0.min_val, tv[i].e_min);
            cmp($sformatf("v%0d.min_idx", i), bus0.min_idx, tv[i].e_midx);
         end
`endif
         if (i == 16) begin
            cmp("ow.entry0", bus1.q_all[0 +: W], 99);
            cmp("ow.ptr", bus1.wr_ptr, 1);
            cmp("ow.ack", bus1.wr_ack, 1);
         end
      end

      // Random traffic, with one mid-run asynchronous reset.
      for (int n = 0; n < 600; n++) begin
         bit s, w, m; int a, d;
         if (n == 300) clear_n = 1'b0;
         if (n == 302) clear_n = 1'b1;
         s = ($urandom_range(0, 31) == 0);
         w = ($urandom_range(0, 3) != 0);
         m = $urandom_range(0, 1);
         a = $urandom_range(0, 7);
         d = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 15) : int'($urandom);
         step(s, w, m, a, d);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ram_dist_buffer.md
Name: ram_dist_buffer

Overview:
Parametrised successor of the 6×13-bit distributed RAM. All entries are readable in parallel as one flattened bus. Writes are staged through a one-deep pipeline with two write modes: addressed, or auto-increment with a write pointer. It tracks which entries hold valid data, flags full/overflow/address errors, and can optionally report the minimum stored value. It sits between the sensor/measurement capture logic and the solver control FSM.

Parameters:
WIDTH, 13, bits per entry
DEPTH, 6, number of entries (2..64)
OVERWRITE, 0, 1 = auto-mode writes wrap and overwrite when full; 0 = drop when full
AW (localparam), $clog2(DEPTH), address/pointer width

Ports:
clk  in  1  system clock, rising edge
clear_n  in  1  asynchronous active-low reset
sclr  in  1  synchronous clear of all entries/state
mode  in  1  0 = addressed write, 1 = auto-increment write
we  in  1  write request, one per cycle
addr  in  AW  write address (mode 0 only)
data  in  WIDTH  write data
q_all  out  WIDTH*DEPTH  entry i on bits [i*WIDTH +: WIDTH]
valid_mask  out  DEPTH  bit i set once entry i is written since clear
wr_ptr  out  AW  next auto-mode address
full  out  1  all valid_mask bits set
wr_ack  out  1  pulse: staged write committed this cycle
wr_err  out  1  pulse: staged write dropped (bad address or full)
min_val  out  WIDTH  minimum over valid entries (feature)
min_idx  out  AW  index of that minimum (feature)

Behaviour:
- Reset (clear_n low, async): all entries, valid_mask, wr_ptr, stage regs, wr_ack, wr_err, min_val, min_idx = 0; full = 0.
- Stage: if we=1 at edge N, capture {mode, addr, data} into the stage; commit at edge N+1.
  - New data is visible on q_all and valid_mask after edge N+1.
  - wr_ack or wr_err is high for the cycle after edge N+1.
- Back-to-back writes are allowed (one per cycle, pipelined). The stage is overwritten each cycle.
- Target address resolution at commit:
  - Mode 0: target = staged addr. If addr ≥ DEPTH: no write, wr_err = 1.
  - Mode 1: target = wr_ptr. wr_ptr increments, and wraps DEPTH-1 → 0.
  - Mode 1 with full=1 and OVERWRITE=0: no write, wr_ptr holds, wr_err = 1.
  - Mode 1 with full=1 and OVERWRITE=1: write proceeds and wr_ack = 1.
- Mode-0 writes never move wr_ptr, but they do set valid_mask.
- full is combinational from valid_mask (&valid_mask).
- sclr takes priority over everything, including a pending stage.
  - At an sclr edge: entries, valid_mask, wr_ptr cleared; stage invalidated; no ack/err for the discarded write.
  - A we in the same cycle as sclr is ignored.
- q_all is driven directly from the storage registers, with no read latency.
- All DEPTH entries are cleared, including the last entry.

Optional Feature:
RAM_DIST_MIN_TRACK_EN
- Defined: min_val/min_idx are registered, updated one cycle after any q_all/valid_mask change.
  - Scope is the valid entries only. Ties resolve to the lowest index.
  - With no valid entries: min_val = all ones, min_idx = 0.
- Undefined: the ports still exist, tied to 0. No comparator logic is synthesised.

Decomposition:
- Package ram_dist_pkg holds:
  - default WIDTH/DEPTH
  - mode encodings MODE_ADDR=1'b0, MODE_AUTO=1'b1
  - MIN_EMPTY_VAL constant
- One sub-module, ram_dist_min: parametrised combinational min/argmin reduction over the flattened bus and mask. Instantiated only under the macro.

Test Plan:
- Reset: hold clear_n=0 with we=1 → q_all=0, valid_mask=0, wr_ptr=0, no ack. Release, then write addr=5, data=13'h1ABC → q_all[5] = 1ABC two edges after the request, wr_ack pulses once, valid_mask=6'b100000.
- Auto fill: mode=1, six back-to-back writes 10..15 → entries 0..5 = 10..15, full=1 after the 6th commit, wr_ptr=0. A 7th write (OVERWRITE=0) gives wr_err=1, entry 0 stays 10.
- Overwrite: OVERWRITE=1, repeat the fill, then write 99 → entry 0 = 99, wr_ptr=1, wr_ack=1.
- Bad address: mode 0, addr=6 or 7 → no entry changes, wr_err=1, valid_mask unchanged.
- sclr collision: commit pending and sclr=1 with we=1 in the same cycle → all entries 0, valid_mask 0, wr_ptr 0, no ack/err in the following cycle.
- Min (macro on): write 300@1, 120@3, 120@4 → min_val=120, min_idx=3 one cycle after the last commit. After sclr → min_val=13'h1FFF, min_idx=0.
